// File: rtl/arbitro_param_if.sv
// Handshake bundle between input FIFOs, output FIFOs and the arbiter.
// The master side is the arbiter; the slave side is the FIFO fabric.
interface arbitro_param_if #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int SEL_W  = 2,
   parameter int DEST_W = 2,
   parameter int CNT_W  = 8
) ();
   logic [N_IN-1:0]   empty;
   logic [N_OUT-1:0]  full;
   logic [DEST_W-1:0] destino;
   logic [N_IN-1:0]   pop;
   logic [N_OUT-1:0]  push;
   logic [SEL_W-1:0]  demux;
   logic              stall;
   logic              err;
   logic [CNT_W-1:0]  push_cnt;

   modport master (
      input  empty, full, destino,
      output pop, push, demux, stall, err, push_cnt
   );

   modport slave (
      output empty, full, destino,
      input  pop, push, demux, stall, err, push_cnt
   );
endinterface

// File: rtl/arbitro_param.sv
// Moves one word at a time from N_IN input FIFOs to N_OUT output FIFOs,
// granting inputs by round-robin or fixed priority and routing by the head word's destino.
module arbitro_param #(
   parameter int N_IN    = 4,
   parameter int N_OUT   = 4,
   parameter int SEL_W   = 2,
   parameter int DEST_W  = 2,
   parameter int RR_MODE = 1,
   parameter int CNT_W   = 8
) (
   input  logic           clk,
   input  logic           reset,
   arbitro_param_if.master bus
);

   typedef enum logic [1:0] {IDLE, SEL, POP, PUSH} state_t;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  grant_q, grant_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [DEST_W-1:0] dest_q, dest_d;
   logic [CNT_W-1:0]  push_cnt_q, push_cnt_d;

   logic              any_req;
   logic [SEL_W-1:0]  pick;
   logic              dest_ok;
   logic              dest_full;
   int                idx;

   // Search starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      idx     = 0;
      for (int i = 0; i < N_IN; i++) begin
         idx = (RR_MODE != 0) ? ((int'(rr_ptr_q) + i) % N_IN) : i;
         if (!any_req && !bus.empty[idx]) begin
            any_req = 1'b1;
            pick    = SEL_W'(idx);
         end
      end
   end

   // Out-of-range destinations never stall; they are dropped later with err.
   always_comb begin
      dest_ok   = (int'(bus.destino) < N_OUT);
      dest_full = 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
         if ((bus.destino == DEST_W'(j)) && bus.full[j]) dest_full = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      dest_d     = dest_q;
      push_cnt_d = push_cnt_q;
      bus.pop    = '0;
      bus.push   = '0;
      bus.stall  = 1'b0;
      bus.err    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = pick;
               state_d = SEL;
            end
         end
         SEL: begin
            if (dest_ok && dest_full) begin
               bus.stall = 1'b1;
            end else begin
               dest_d  = bus.destino;
               state_d = POP;
            end
         end
         POP: begin
            for (int i = 0; i < N_IN; i++) begin
               if (grant_q == SEL_W'(i)) bus.pop[i] = 1'b1;
            end
            if (RR_MODE != 0) rr_ptr_d = SEL_W'((int'(grant_q) + 1) % N_IN);
            state_d = PUSH;
         end
         PUSH: begin
            // Full is deliberately not rechecked here: the slot was reserved in SEL.
            if (int'(dest_q) < N_OUT) begin
               for (int j = 0; j < N_OUT; j++) begin
                  if (dest_q == DEST_W'(j)) bus.push[j] = 1'b1;
               end
               push_cnt_d = push_cnt_q + CNT_W'(1);
            end else begin
               bus.err = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         dest_q     <= '0;
         push_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         dest_q     <= dest_d;
         push_cnt_q <= push_cnt_d;
      end
   end

   assign bus.demux    = grant_q;
   assign bus.push_cnt = push_cnt_q;

endmodule

// File: tb/tb_arbitro_param.sv
// Directed bench for arbitro_param: round-robin, fixed-priority and narrow-output
// instances driven with hand-computed vectors.
module tb_arbitro_param;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   arbitro_param_if #(.N_IN(4), .N_OUT(4), .SEL_W(2), .DEST_W(2), .CNT_W(8)) b0 ();
   arbitro_param_if #(.N_IN(4), .N_OUT(4), .SEL_W(2), .DEST_W(2), .CNT_W(8)) b1 ();
   arbitro_param_if #(.N_IN(4), .N_OUT(3), .SEL_W(2), .DEST_W(2), .CNT_W(2)) b2 ();

   arbitro_param #(.N_IN(4), .N_OUT(4), .SEL_W(2), .DEST_W(2), .RR_MODE(1), .CNT_W(8))
      u0 (.clk(clk), .reset(reset), .bus(b0));
   arbitro_param #(.N_IN(4), .N_OUT(4), .SEL_W(2), .DEST_W(2), .RR_MODE(0), .CNT_W(8))
      u1 (.clk(clk), .reset(reset), .bus(b1));
   arbitro_param #(.N_IN(4), .N_OUT(3), .SEL_W(2), .DEST_W(2), .RR_MODE(1), .CNT_W(2))
      u2 (.clk(clk), .reset(reset), .bus(b2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int onehot;
      reset = 1'b0;
      b0.empty = 4'b1111; b0.full = 4'b0000; b0.destino = 2'd0;
      b1.empty = 4'b1111; b1.full = 4'b0000; b1.destino = 2'd0;
      b2.empty = 4'b1111; b2.full = 3'b000;  b2.destino = 2'd0;
      #12;
      check("rst_pop",   32'(b0.pop),      32'h0);
      check("rst_push",  32'(b0.push),     32'h0);
      check("rst_demux", 32'(b0.demux),    32'h0);
      check("rst_stall", 32'(b0.stall),    32'h0);
      check("rst_err",   32'(b0.err),      32'h0);
      check("rst_cnt",   32'(b0.push_cnt), 32'h0);
      reset = 1'b1;

      // Basic transfer: input 0 to output 2
      b0.empty = 4'b1010; b0.destino = 2'd2;
      tick();
      check("t1_sel_demux", 32'(b0.demux), 32'h0);
      check("t1_sel_pop",   32'(b0.pop),   32'h0);
      check("t1_sel_stall", 32'(b0.stall), 32'h0);
      tick();
      check("t1_pop",       32'(b0.pop),   32'h1);
      check("t1_pop_push",  32'(b0.push),  32'h0);
      b0.empty = 4'b1111;
      tick();
      check("t1_push",      32'(b0.push),  32'h4);
      check("t1_push_pop",  32'(b0.pop),   32'h0);
      tick();
      check("t1_idle_push", 32'(b0.push),  32'h0);
      check("t1_cnt",       32'(b0.push_cnt), 32'h1);

      // Asynchronous reset clears the counter without a clock edge
      reset = 1'b0;
      #1;
      check("arst_cnt", 32'(b0.push_cnt), 32'h0);
      #1;
      reset = 1'b1;

      // Round-robin vs fixed priority with all inputs busy
      b0.empty = 4'b0000; b0.destino = 2'd3;
      b1.empty = 4'b0000; b1.destino = 2'd3;
      for (int g = 0; g < 5; g++) begin
         onehot = 32'(1) << (g % 4);
         tick();
         check("rr_demux",  32'(b0.demux), 32'(g % 4));
         check("fix_demux", 32'(b1.demux), 32'h0);
         tick();
         check("rr_pop",    32'(b0.pop),   32'(onehot));
         check("fix_pop",   32'(b1.pop),   32'h1);
         tick();
         check("rr_push",   32'(b0.push),  32'h8);
         check("fix_push",  32'(b1.push),  32'h8);
         if (g == 4) begin
            b0.empty = 4'b1111;
            b1.empty = 4'b1111;
         end
         tick();
      end
      check("rr_cnt",  32'(b0.push_cnt), 32'd5);
      check("fix_cnt", 32'(b1.push_cnt), 32'd5);

      // Stall on a full destination for five SEL cycles
      b0.empty = 4'b1110; b0.destino = 2'd1; b0.full = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("st_stall", 32'(b0.stall), 32'h1);
         check("st_pop",   32'(b0.pop),   32'h0);
      end
      b0.full = 4'b0000;
      #1;
      check("st_release", 32'(b0.stall), 32'h0);
      tick();
      check("st_pop_go",  32'(b0.pop),   32'h1);
      b0.empty = 4'b1111;
      tick();
      check("st_push",    32'(b0.push),  32'h2);
      tick();
      check("st_demux_hold", 32'(b0.demux), 32'h0);
      check("st_cnt",     32'(b0.push_cnt), 32'd6);

      // Narrow instance: three pushes, one discarded word, then wrap
      b2.empty = 4'b1110; b2.destino = 2'd0;
      for (int w = 0; w < 3; w++) begin
         tick(); tick(); tick();
         check("n_push", 32'(b2.push), 32'h1);
         tick();
         check("n_cnt",  32'(b2.push_cnt), 32'(w + 1));
      end
      b2.destino = 2'd3;
      tick();
      check("e_stall", 32'(b2.stall), 32'h0);
      tick();
      check("e_pop",   32'(b2.pop),   32'h1);
      b2.destino = 2'd0;
      tick();
      check("e_push",  32'(b2.push),  32'h0);
      check("e_err",   32'(b2.err),   32'h1);
      tick();
      check("e_err_end", 32'(b2.err), 32'h0);
      check("e_cnt",   32'(b2.push_cnt), 32'd3);
      tick(); tick(); tick();
      check("w_push",  32'(b2.push),  32'h1);
      b2.empty = 4'b1111;
      tick();
      check("w_cnt",   32'(b2.push_cnt), 32'h0);

      // Reset asserted during POP aborts the transfer
      b0.empty = 4'b1101; b0.destino = 2'd0;
      tick();
      check("r_demux", 32'(b0.demux), 32'h1);
      tick();
      check("r_pop",   32'(b0.pop),   32'h2);
      reset = 1'b0;
      #1;
      check("r_pop_drop",  32'(b0.pop),      32'h0);
      check("r_push",      32'(b0.push),     32'h0);
      check("r_demux_clr", 32'(b0.demux),    32'h0);
      check("r_cnt",       32'(b0.push_cnt), 32'h0);
      check("r_stall",     32'(b0.stall),    32'h0);
      check("r_err",       32'(b0.err),      32'h0);
      b0.empty = 4'b0000;
      tick();
      check("r_hold_pop",  32'(b0.pop),  32'h0);
      check("r_hold_push", 32'(b0.push), 32'h0);
      reset = 1'b1;
      tick();
      check("r_first_grant", 32'(b0.demux), 32'h0);
      tick();
      check("r_first_pop",   32'(b0.pop),   32'h1);
      b0.empty = 4'b1111;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arbitro_param.md
ARBITRO_PARAM -- requirements
Module: arbitro_param

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of input FIFOs (2..16).
REQ-002 SHALL have parameter N_OUT, default 4: number of output FIFOs (2..16).
REQ-003 SHALL have parameter SEL_W, default 2: width of demux; ceil(log2(N_IN)).
REQ-004 SHALL have parameter DEST_W, default 2: width of destino; ceil(log2(N_OUT)).
REQ-005 SHALL have parameter RR_MODE, default 1: 1 = round-robin grant, 0 = fixed priority (index 0 highest).
REQ-006 SHALL have parameter CNT_W, default 8: width of push_cnt.
REQ-007 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 empty  input  N_IN  empty flag per input FIFO.
REQ-011 full  input  N_OUT  full flag per output FIFO.
REQ-012 destino  input  DEST_W  destination field of the head word of the input selected by demux (show-ahead); valid in SEL.
REQ-013 pop  output  N_IN  one-hot pop strobe.
REQ-014 push  output  N_OUT  one-hot push strobe.
REQ-015 demux  output  SEL_W  index of the granted input; steers data path.
REQ-016 stall  output  1  high while the granted word is blocked by a full destination.
REQ-017 err  output  1  one-cycle pulse when a word with destino >= N_OUT is discarded.
REQ-018 push_cnt  output  CNT_W  count of successful pushes, wraps.

Function
REQ-019 States SHALL be IDLE, SEL, POP, PUSH; all state, grant, dest_q, rr_ptr and push_cnt are registered.
REQ-020 IDLE: if any empty[i]==0, grant index g SHALL be latched and next state is SEL; otherwise stay in IDLE.
REQ-021 Fixed mode: g = lowest i with empty[i]==0; RR mode: g = first non-empty index searching rr_ptr, rr_ptr+1, ... mod N_IN.
REQ-022 demux SHALL equal latched g in SEL, POP and PUSH, and hold its last value in IDLE.
REQ-023 SEL: if destino < N_OUT and full[destino]==1, stall=1 and stay in SEL; else destino SHALL be latched into dest_q and next state is POP.
REQ-024 POP: pop[g]=1 for exactly this one cycle; in RR mode rr_ptr <= (g+1) mod N_IN; next state PUSH.
REQ-025 PUSH: if dest_q < N_OUT, push[dest_q]=1 and push_cnt increments by 1 modulo 2^CNT_W; else no push and err=1; next state IDLE.
REQ-026 Latency: non-empty sampled in IDLE at edge k -> SEL cycle k+1, pop cycle k+2, push cycle k+3 (no stall), IDLE cycle k+4; max throughput one word per 4 cycles.
REQ-027 pop and push SHALL never both be non-zero in the same cycle; each SHALL be zero or one-hot.
REQ-028 Changes of empty during SEL/POP/PUSH SHALL NOT alter g; changes of destino after leaving SEL SHALL NOT alter dest_q.
REQ-029 full[dest_q] rising during POP or PUSH SHALL NOT cancel the push (full is checked only in SEL).
REQ-030 A stall SHALL persist indefinitely until full[destino] falls; no other input is granted meanwhile (no word reordering).
REQ-031 Unused codes of state SHALL return to IDLE on the next edge with all strobes low.

Reset
REQ-032 reset==0 SHALL immediately force state IDLE, pop=0, push=0, demux=0, stall=0, err=0, push_cnt=0, rr_ptr=0, dest_q=0, independent of clk.
REQ-033 Reset asserted mid-transfer (SEL/POP/PUSH) SHALL abort it; no pop or push is issued after reset assertion; first grant after release follows REQ-020 with rr_ptr=0.

Verification
REQ-034 Defaults; empty=4'b1010, full=0, destino=2 -> SEL demux=0, pop=4'b0001, then push=4'b0100, push_cnt=1.
REQ-035 RR_MODE=1; empty=4'b0000 held, destino=3 -> grants 0,1,2,3,0 in order, pops every 4 cycles, push=4'b1000 each time.
REQ-036 RR_MODE=0; same stimulus -> every grant is input 0.
REQ-037 empty=4'b1110, destino=1, full=4'b0010 for 5 cycles -> stall=1 for 5 SEL cycles, pop=0; full falls -> pop=4'b0001, push=4'b0010.
REQ-038 N_OUT=3, DEST_W=2, destino=3 -> pop issued, push=0, err=1 for one cycle, push_cnt unchanged.
REQ-039 reset low during POP cycle -> pop drops to 0 before next edge, all outputs 0; CNT_W=2 with 4 pushes -> push_cnt wraps to 0.
